// File: rtl/img_pkg.sv
// Shared image-path definitions for the pixel loader and the block compressor stage.
package img_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned BLK_PIX = 8;
    localparam int unsigned IMG_PIX = 16;
    localparam int unsigned BLK_W   = PIX_W * BLK_PIX;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } loader_state_e;

endpackage

// File: rtl/blk_hold_reg.sv
// Output slot of the pixel block loader: holds one block with its index, last flag and
// optional checksum (BLK_CHKSUM_EN) under a valid/ready handshake.
module blk_hold_reg #(
`ifdef BLK_CHKSUM_EN
    parameter int unsigned SUM_W  = 11,
`endif
    parameter int unsigned DATA_W = 64,
    parameter int unsigned IDX_W  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              last_i,
`ifdef BLK_CHKSUM_EN
    input  logic [SUM_W-1:0]  sum_i,
    output logic [SUM_W-1:0]  sum_o,
`endif
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              last_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;
`ifdef BLK_CHKSUM_EN
    logic [SUM_W-1:0]  sum_q, sum_d;
`endif

    // A load on the handshake edge wins, giving back-to-back blocks without a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
`ifdef BLK_CHKSUM_EN
        sum_d   = sum_q;
`endif
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            idx_d   = idx_i;
            last_d  = last_i;
`ifdef BLK_CHKSUM_EN
            sum_d   = sum_i;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
`ifdef BLK_CHKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef BLK_CHKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;
    assign last_o  = last_q;
`ifdef BLK_CHKSUM_EN
    assign sum_o   = sum_q;
`endif

endmodule

// File: rtl/pixel_block_loader.sv
// Streams pixels over valid/ready and packs them into BLK_PIX-pixel blocks for the
// compressor. Optional per-block checksum output when BLK_CHKSUM_EN is defined.
module pixel_block_loader #(
    parameter int unsigned PIX_W   = img_pkg::PIX_W,
    parameter int unsigned BLK_PIX = img_pkg::BLK_PIX,
    parameter int unsigned IMG_PIX = img_pkg::IMG_PIX,
    localparam int unsigned BlkW   = PIX_W * BLK_PIX,
    localparam int unsigned NumBlk = IMG_PIX / BLK_PIX,
    localparam int unsigned IdxW   = (NumBlk > 1) ? $clog2(NumBlk) : 1
`ifdef BLK_CHKSUM_EN
    ,
    localparam int unsigned SumW   = PIX_W + $clog2(BLK_PIX)
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [BlkW-1:0]  blk_out,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [IdxW-1:0]  blk_idx,
    output logic             blk_last,
    output logic             busy,
    output logic             done
`ifdef BLK_CHKSUM_EN
    ,
    output logic [SumW-1:0]  blk_sum
`endif
);

    import img_pkg::*;

    localparam int unsigned CntW = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;

    if ((IMG_PIX == 0) || ((IMG_PIX % BLK_PIX) != 0)) begin : g_bad_img_pix
        $error("IMG_PIX must be a nonzero multiple of BLK_PIX");
    end

    loader_state_e   state_q, state_d;
    logic [CntW-1:0] pix_cnt_q, pix_cnt_d;
    logic [IdxW-1:0] asm_blk_q, asm_blk_d;
    logic [IdxW-1:0] out_idx_q, out_idx_d;
    logic [BlkW-1:0] asm_q, asm_d;
    logic            asm_full_q, asm_full_d;

    logic            pix_fire, blk_fire, last_pix, slot_free;
    logic            load_now, load_held, load;
    logic [BlkW-1:0] load_data;

    assign pix_ready = (state_q == FILL) && !asm_full_q;
    assign pix_fire  = pix_valid && pix_ready;
    assign blk_fire  = blk_valid && blk_ready;
    assign slot_free = !blk_valid || blk_ready;
    assign last_pix  = (pix_cnt_q == CntW'(BLK_PIX - 1));
    // Completed block goes straight to the slot if it is free, else waits in asm_q.
    assign load_now  = pix_fire && last_pix && slot_free;
    assign load_held = asm_full_q && blk_fire;
    assign load      = load_now || load_held;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    always_comb begin
        load_data = asm_q;
        if (load_now) begin
            load_data[(BLK_PIX-1)*PIX_W +: PIX_W] = pix_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        asm_blk_d  = asm_blk_q;
        out_idx_d  = out_idx_q;
        asm_d      = asm_q;
        asm_full_d = asm_full_q;

        if (pix_fire) begin
            asm_d[int'(pix_cnt_q)*PIX_W +: PIX_W] = pix_in;
            if (last_pix) begin
                pix_cnt_d  = '0;
                asm_blk_d  = asm_blk_q + 1'b1;
                asm_full_d = !slot_free;
                if (asm_blk_q == IdxW'(NumBlk - 1)) begin
                    state_d = DRAIN;
                end
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end
        if (load_held) begin
            asm_full_d = 1'b0;
        end
        if (load) begin
            out_idx_d = out_idx_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FILL;
                    pix_cnt_d  = '0;
                    asm_blk_d  = '0;
                    out_idx_d  = '0;
                    asm_full_d = 1'b0;
                end
            end
            FILL: ;
            DRAIN: begin
                if (blk_fire && blk_last) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef BLK_CHKSUM_EN
    logic [SumW-1:0] sum_q, sum_d, sum_next, load_sum;

    // While a completed block waits in asm_q, sum_q keeps its total; pixels are stalled.
    assign sum_next = sum_q + SumW'(pix_in);
    assign load_sum = load_now ? sum_next : sum_q;

    always_comb begin
        sum_d = sum_q;
        if (pix_fire) begin
            sum_d = (last_pix && slot_free) ? '0 : sum_next;
        end
        if (load_held || ((state_q == IDLE) && start)) begin
            sum_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            asm_blk_q  <= '0;
            out_idx_q  <= '0;
            asm_q      <= '0;
            asm_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            asm_blk_q  <= asm_blk_d;
            out_idx_q  <= out_idx_d;
            asm_q      <= asm_d;
            asm_full_q <= asm_full_d;
        end
    end

    blk_hold_reg #(
`ifdef BLK_CHKSUM_EN
        .SUM_W  (SumW),
`endif
        .DATA_W (BlkW),
        .IDX_W  (IdxW)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .data_i  (load_data),
        .idx_i   (out_idx_q),
        .last_i  (out_idx_q == IdxW'(NumBlk - 1)),
`ifdef BLK_CHKSUM_EN
        .sum_i   (load_sum),
        .sum_o   (blk_sum),
`endif
        .ready_i (blk_ready),
        .valid_o (blk_valid),
        .data_o  (blk_out),
        .idx_o   (blk_idx),
        .last_o  (blk_last)
    );

endmodule

// File: tb/tb_pixel_block_loader.sv
// Scoreboard bench for pixel_block_loader (default 8-bit pixels, 8-pixel blocks,
// 16-pixel images); checksum scenario enabled with BLK_CHKSUM_EN.
module tb_pixel_block_loader;

    localparam int NB = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [63:0] blk_out;
    logic        blk_valid;
    logic        blk_ready = 1'b0;
    logic [0:0]  blk_idx;
    logic        blk_last;
    logic        busy;
    logic        done;
`ifdef BLK_CHKSUM_EN
    logic [10:0] blk_sum;
`endif

    always #5 clk = ~clk;

    pixel_block_loader u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .blk_out   (blk_out),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_idx   (blk_idx),
        .blk_last  (blk_last),
        .busy      (busy),
`ifdef BLK_CHKSUM_EN
        .blk_sum   (blk_sum),
`endif
        .done      (done)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [0:0]  idx;
        logic        last;
        logic [10:0] sum;
    } blk_t;

    blk_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [63:0] m_asm;
    int          m_cnt;
    int          m_blk;
    int          m_sum;

    task automatic model_start();
        m_asm = '0;
        m_cnt = 0;
        m_blk = 0;
        m_sum = 0;
    endtask

    task automatic model_pixel(input logic [7:0] d);
        blk_t e;
        m_asm[m_cnt*8 +: 8] = d;
        m_sum += int'(d);
        if (m_cnt == 7) begin
            e.data = m_asm;
            e.idx  = 1'(m_blk);
            e.last = (m_blk == NB - 1);
            e.sum  = 11'(m_sum);
            exp_q.push_back(e);
            m_asm = '0;
            m_cnt = 0;
            m_sum = 0;
            m_blk = (m_blk + 1) % NB;
        end else begin
            m_cnt++;
        end
    endtask

    // Drive one cycle's inputs after the falling edge; report the handshakes due next edge.
    task automatic cycle(input logic st, input logic pv, input logic [7:0] pd,
                         input logic br, output logic pf, output logic bf);
        @(negedge clk);
        start     = st;
        pix_valid = pv;
        pix_in    = pd;
        blk_ready = br;
        #1;
        cyc++;
        pf = pix_valid && pix_ready;
        bf = blk_valid && blk_ready;
        if (pf) model_pixel(pd);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        pix_valid = 1'b0;
        blk_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({pix_ready, blk_valid, blk_last, busy, done} !== 5'b0 || blk_out !== 64'h0
            || blk_idx !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: ctl=%b out=%h idx=%b want ctl=00000 out=0 idx=0",
                     {pix_ready, blk_valid, blk_last, busy, done}, blk_out, blk_idx);
        end
        apply_reset();
        #1;
        n_vec++;
        if (busy !== 1'b0 || pix_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b pix_ready=%b want 0 0", busy, pix_ready);
        end
    endtask

    // Back-to-back image; optionally pulse start again after 3 pixels (must be ignored).
    task automatic test_stream(input bit restart);
        logic pf, bf;
        blk_t e;
        int sent = 0, got = 0, dones = 0, p7 = -1, b0 = -1;
        apply_reset();
        model_start();
        cycle(1'b1, 1'b0, 8'h00, 1'b1, pf, bf);
        for (int i = 0; i < 30; i++) begin
            cycle(restart && sent == 3, sent < 16, 8'(sent), 1'b1, pf, bf);
            if (pf) begin
                if (sent == 7) p7 = cyc;
                sent++;
            end
            if (bf) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_extra_block: got %h with nothing expected", blk_out);
                end else begin
                    e = exp_q.pop_front();
                    if (blk_out !== e.data || blk_idx !== e.idx || blk_last !== e.last) begin
                        n_err++;
                        $display("FAIL stream_block%0d: got %h idx%b last%b want %h idx%b last%b",
                                 got, blk_out, blk_idx, blk_last, e.data, e.idx, e.last);
                    end
                end
                if (got == 0) begin
                    b0 = cyc;
                    n_vec++;
                    if (blk_out !== 64'h0706050403020100) begin
                        n_err++;
                        $display("FAIL stream_blk0_const: got %h want 0706050403020100", blk_out);
                    end
                end
                got++;
            end
            if (done) dones++;
        end
        n_vec++;
        if (sent != 16 || got != 2 || dones != 1 || exp_q.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stream_totals: pix=%0d blks=%0d dones=%0d left=%0d busy=%b want 16 2 1 0 0",
                     sent, got, dones, exp_q.size(), busy);
        end
        n_vec++;
        if (b0 - p7 != 1) begin
            n_err++;
            $display("FAIL stream_latency: got %0d cycles want 1", b0 - p7);
        end
    endtask

    task automatic test_backpressure();
        logic pf, bf;
        blk_t e;
        logic [63:0] held = '0;
        bit have = 0;
        int sent = 0, got = 0, dones = 0, c0 = 0, c1 = 0;
        apply_reset();
        model_start();
        cycle(1'b1, 1'b0, 8'h00, 1'b0, pf, bf);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b1, 8'(sent), 1'b0, pf, bf);
            if (pf) sent++;
            if (blk_valid && !have) begin
                held = blk_out;
                have = 1;
            end else if (have) begin
                n_vec++;
                if (blk_valid !== 1'b1 || blk_out !== held || blk_idx !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold_stable: v=%b out=%h idx=%b want 1 %h 0",
                             blk_valid, blk_out, blk_idx, held);
                end
            end
        end
        n_vec++;
        if (sent != 16 || pix_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backlog: accepted=%0d pix_ready=%b want 16 0", sent, pix_ready);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, pf, bf);
            if (bf) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra_block: got %h with nothing expected", blk_out);
                end else begin
                    e = exp_q.pop_front();
                    if (blk_out !== e.data || blk_idx !== e.idx || blk_last !== e.last) begin
                        n_err++;
                        $display("FAIL bp_block%0d: got %h idx%b last%b want %h idx%b last%b",
                                 got, blk_out, blk_idx, blk_last, e.data, e.idx, e.last);
                    end
                end
                if (got == 0) c0 = cyc;
                else c1 = cyc;
                got++;
            end
            if (done) dones++;
        end
        n_vec++;
        if (got != 2 || c1 - c0 != 1 || dones != 1) begin
            n_err++;
            $display("FAIL bp_release: blks=%0d gap=%0d dones=%0d want 2 1 1", got, c1 - c0, dones);
        end
    endtask

    task automatic test_reset_abort();
        logic pf, bf;
        blk_t e;
        int sent = 0, got = 0;
        apply_reset();
        model_start();
        cycle(1'b1, 1'b0, 8'h00, 1'b1, pf, bf);
        for (int i = 0; i < 10 && sent < 5; i++) begin
            cycle(1'b0, 1'b1, 8'(sent), 1'b1, pf, bf);
            if (pf) sent++;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (pix_ready !== 1'b0 || blk_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset: pix_ready=%b blk_valid=%b busy=%b want 0 0 0",
                     pix_ready, blk_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_start();
        sent = 0;
        cycle(1'b1, 1'b0, 8'h00, 1'b1, pf, bf);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, sent < 16, 8'(8'h10 + sent), 1'b1, pf, bf);
            if (pf) sent++;
            if (bf) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL abort_extra_block: got %h with nothing expected", blk_out);
                end else begin
                    e = exp_q.pop_front();
                    if (blk_out !== e.data || blk_idx !== e.idx || blk_last !== e.last) begin
                        n_err++;
                        $display("FAIL abort_block%0d: got %h idx%b last%b want %h idx%b last%b",
                                 got, blk_out, blk_idx, blk_last, e.data, e.idx, e.last);
                    end
                end
                if (got == 0) begin
                    n_vec++;
                    if (blk_out !== 64'h1716151413121110) begin
                        n_err++;
                        $display("FAIL abort_blk0_const: got %h want 1716151413121110", blk_out);
                    end
                end
                got++;
            end
        end
        n_vec++;
        if (got != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL abort_totals: blks=%0d left=%0d want 2 0", got, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic pf, bf;
        blk_t e;
        apply_reset();
        for (int img = 0; img < 4; img++) begin
            int sent = 0, got = 0;
            bit seen_done = 0;
            model_start();
            cycle(1'b1, 1'b0, 8'h00, 1'b0, pf, bf);
            for (int i = 0; i < 400 && !seen_done; i++) begin
                cycle(1'b0, (sent < 16) && ($urandom_range(0, 9) < 7),
                      8'($urandom_range(0, 255)), $urandom_range(0, 9) < 6, pf, bf);
                if (pf) sent++;
                if (bf) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rand_dup_block: img%0d got %h with nothing expected",
                                 img, blk_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (blk_out !== e.data || blk_idx !== e.idx || blk_last !== e.last) begin
                            n_err++;
                            $display("FAIL rand_block: img%0d got %h idx%b last%b want %h idx%b last%b",
                                     img, blk_out, blk_idx, blk_last, e.data, e.idx, e.last);
                        end
                    end
                    got++;
                end
                if (done) seen_done = 1;
            end
            n_vec++;
            if (!seen_done || got != 2 || exp_q.size() != 0) begin
                n_err++;
                $display("FAIL rand_image%0d: done=%0d blks=%0d left=%0d want 1 2 0",
                         img, seen_done, got, exp_q.size());
            end
        end
    endtask

`ifdef BLK_CHKSUM_EN
    task automatic test_chksum();
        logic pf, bf;
        blk_t e;
        int sent = 0, got = 0;
        logic [10:0] want_c;
        apply_reset();
        model_start();
        cycle(1'b1, 1'b0, 8'h00, 1'b1, pf, bf);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, sent < 16, 8'(sent), 1'b1, pf, bf);
            if (pf) sent++;
            if (bf) begin
                want_c = (got == 0) ? 11'd28 : 11'd92;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sum_extra_block: got %h with nothing expected", blk_out);
                end else begin
                    e = exp_q.pop_front();
                    if (blk_sum !== e.sum || blk_sum !== want_c) begin
                        n_err++;
                        $display("FAIL blk_sum%0d: got %0d want %0d", got, blk_sum, want_c);
                    end
                end
                got++;
            end
        end
        n_vec++;
        if (got != 2) begin
            n_err++;
            $display("FAIL sum_totals: blks=%0d want 2", got);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream(1'b0);
        test_backpressure();
        test_stream(1'b1);
        test_reset_abort();
        test_random();
`ifdef BLK_CHKSUM_EN
        test_chksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
